// File: rtl/serial_ip_pkg.sv
// Shared types and width helpers for the bit-serial inner-product block.
package serial_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2; used with power-of-2 lane counts.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Adder-tree output width: synapse width plus one bit per tree level plus
  // one bit of headroom for the negated first slice.
  function automatic int unsigned tree_w(input int unsigned n, input int unsigned ti);
    return n + log2c(ti) + 1;
  endfunction

  // Accumulator width: tree width plus one bit per neuron bit-slice.
  function automatic int unsigned acc_w(input int unsigned n, input int unsigned ti,
                                        input int unsigned pmax);
    return n + log2c(ti) + pmax + 1;
  endfunction

  localparam int unsigned TREE_W = tree_w(16, 16);
  localparam int unsigned ACC_W  = acc_w(16, 16, 16);

endpackage

// File: rtl/serial_ip_prec_if.sv
// Operand/result bus of serial_ip_prec. master = requester, slave = engine.
interface serial_ip_prec_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned TI = 16
);
  import serial_ip_pkg::*;

  logic          i_start;
  logic [4:0]    i_precision;
  logic          i_signed;
  logic [N-1:0]  i_nbout;
  logic          i_valid;
  logic          o_ready;
  logic [TI-1:0] i_neurons;
  logic [TI*N-1:0] i_synapses;
  logic [N-1:0]  o_result;
  logic          o_valid;
  logic          i_result_ready;
  logic          o_busy;

  modport master (
    output i_start, i_precision, i_signed, i_nbout, i_valid, i_neurons,
           i_synapses, i_result_ready,
    input  o_ready, o_result, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_precision, i_signed, i_nbout, i_valid, i_neurons,
           i_synapses, i_result_ready,
    output o_ready, o_result, o_valid, o_busy
  );

endinterface

// File: rtl/serial_adder_tree.sv
// TI-input pipelined adder tree with a single register stage at mid-depth.
// A valid tag follows the data through the register stage.
module serial_adder_tree
  import serial_ip_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned TI = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [TI*tree_w(N,TI)-1:0] i_data,
  output logic                       o_valid,
  output logic [tree_w(N,TI)-1:0]    o_sum
);

  localparam int unsigned W   = tree_w(N, TI);
  localparam int unsigned LV  = log2c(TI);
  localparam int unsigned MID = (LV + 1) / 2;

  logic r_vld;

  for (genvar k = 0; k <= LV; k++) begin : g_lvl
    logic [W-1:0] w_node [TI>>k];
    if (k == 0) begin : g_in
      for (genvar j = 0; j < TI; j++) begin : g_j
        assign w_node[j] = i_data[j*W +: W];
      end
    end else begin : g_sum
      for (genvar j = 0; j < (TI >> k); j++) begin : g_j
        if (k == MID) begin : g_reg
          logic [W-1:0] r_sum;
          // Mid-depth pipeline register for partial sums.
          always_ff @(posedge clk) begin
            if (reset) r_sum <= '0;
            else       r_sum <= g_lvl[k-1].w_node[2*j] + g_lvl[k-1].w_node[2*j+1];
          end
          assign w_node[j] = r_sum;
        end else begin : g_add
          assign w_node[j] = g_lvl[k-1].w_node[2*j] + g_lvl[k-1].w_node[2*j+1];
        end
      end
    end
  end

  // Valid tag matching the single register stage.
  always_ff @(posedge clk) begin
    if (reset) r_vld <= 1'b0;
    else       r_vld <= i_valid;
  end

  assign o_valid = r_vld;
  assign o_sum   = g_lvl[LV].w_node[0];

endmodule

// File: rtl/serial_ip_prec.sv
// Bit-serial precision inner product: TI lanes, neuron bits MSB first,
// shift-accumulate of adder-tree sums, plus a latched partial sum.
// Optional macro SERIAL_IP_PREC_SATURATE_EN: clamp result to N-bit signed
// range instead of wrapping.
module serial_ip_prec
  import serial_ip_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned TI   = 16,
  parameter int unsigned PMAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [4:0]      i_precision,
  input  logic            i_signed,
  input  logic [N-1:0]    i_nbout,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [TI-1:0]   i_neurons,
  input  logic [TI*N-1:0] i_synapses,
  output logic [N-1:0]    o_result,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic            o_busy
);

  localparam int unsigned TW = tree_w(N, TI);
  localparam int unsigned AW = acc_w(N, TI, PMAX);
  localparam logic [4:0] PMAX_P = 5'(PMAX);

  state_t          r_state;
  logic [4:0]      r_peff;
  logic [4:0]      r_cnt;
  logic [1:0]      r_dcnt;
  logic            r_sgn;
  logic [N-1:0]    r_nbout;
  logic [AW-1:0]   r_acc;
  logic            r_ready;
  logic            r_valid;
  logic [N-1:0]    r_result;

  logic            w_accept;
  logic            w_neg;
  logic [4:0]      w_peff;
  logic [TW-1:0]   w_lane;
  logic [TI*TW-1:0] w_prod;
  logic            w_tvld;
  logic [TW-1:0]   w_tsum;
  logic [N-1:0]    w_red;

  assign w_accept = (r_state == RUN) && i_valid && r_ready;
  assign w_neg    = r_sgn && (r_cnt == 5'd0);
  assign w_peff   = ((i_precision == 5'd0) || (i_precision > PMAX_P)) ? PMAX_P : i_precision;

  // Per-lane gated, sign-extended synapse; first signed slice is negated.
  always_comb begin
    w_lane = '0;
    w_prod = '0;
    for (int unsigned i = 0; i < TI; i++) begin
      w_lane = TW'($signed(i_synapses[i*N +: N])) & {TW{i_neurons[i]}};
      if (w_neg) w_lane = -w_lane;
      w_prod[i*TW +: TW] = w_lane;
    end
  end

  serial_adder_tree #(
    .N  (N),
    .TI (TI)
  ) u_tree (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_data  (w_prod),
    .o_valid (w_tvld),
    .o_sum   (w_tsum)
  );

`ifdef SERIAL_IP_PREC_SATURATE_EN
  localparam logic signed [AW:0] MAXV = {{(AW + 2 - N){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW:0] MINV = ~MAXV;
  logic signed [AW:0] w_full;
  assign w_full = $signed({r_acc[AW-1], r_acc}) + (AW+1)'($signed(r_nbout));
  assign w_red  = (w_full > MAXV) ? MAXV[N-1:0] :
                  (w_full < MINV) ? MINV[N-1:0] : w_full[N-1:0];
`else
  assign w_red = r_acc[N-1:0] + r_nbout;
`endif

  // Control FSM, accumulator and registered outputs. DRAIN counts two edges
  // after the last slice: one for the tree register, one to form the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_peff   <= '0;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_sgn    <= 1'b0;
      r_nbout  <= '0;
      r_acc    <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_tvld) r_acc <= (r_acc << 1) + AW'($signed(w_tsum));
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_peff  <= w_peff;
            r_sgn   <= i_signed;
            r_nbout <= i_nbout;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == r_peff - 5'd1) begin
              r_ready <= 1'b0;
              r_dcnt  <= '0;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_dcnt <= r_dcnt + 2'd1;
          if (r_dcnt == 2'd1) r_result <= w_red;
          if (r_dcnt == 2'd2) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (i_result_ready) begin
            r_valid <= 1'b0;
            if (i_start) begin
              r_peff  <= w_peff;
              r_sgn   <= i_signed;
              r_nbout <= i_nbout;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_ready <= 1'b1;
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_serial_ip_prec.sv
// Scoreboard bench for serial_ip_prec (N=16, TI=16, PMAX=16).
module tb_serial_ip_prec;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   t_last;
  int   rdy_cnt;
  bit   prev_v;
  logic signed [15:0] exp_q[$];

  serial_ip_prec_if #(.N(16), .TI(16)) bus ();

  serial_ip_prec #(.N(16), .TI(16), .PMAX(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (bus.i_start),
    .i_precision    (bus.i_precision),
    .i_signed       (bus.i_signed),
    .i_nbout        (bus.i_nbout),
    .i_valid        (bus.i_valid),
    .o_ready        (bus.o_ready),
    .i_neurons      (bus.i_neurons),
    .i_synapses     (bus.i_synapses),
    .o_result       (bus.o_result),
    .o_valid        (bus.o_valid),
    .i_result_ready (bus.i_result_ready),
    .o_busy         (bus.o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compares every presented result with the scoreboard head,
  // checks the result latency, pops on handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.o_ready) rdy_cnt = rdy_cnt + 1;
      if (bus.o_valid) begin
        if (!prev_v) begin
          total = total + 1;
          if (cyc != t_last + 3) begin
            bad = bad + 1;
            $display("FAIL latency: o_valid after %0d edges, required 3", cyc - t_last);
          end
        end
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_valid: o_result=%0d with no pending request", $signed(bus.o_result));
        end else begin
          if (bus.o_result !== exp_q[0]) begin
            bad = bad + 1;
            $display("FAIL result: got %0d, required %0d", $signed(bus.o_result), exp_q[0]);
          end
          if (bus.i_result_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = bus.o_valid;
    end
  end

  function automatic logic [255:0] all_syn(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic start_op(input logic [4:0] p, input logic s, input logic [15:0] nb,
                          input logic [255:0] syn, input bit push, input logic signed [15:0] expv);
    bus.i_precision = p;
    bus.i_signed    = s;
    bus.i_nbout     = nb;
    bus.i_synapses  = syn;
    bus.i_start     = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic slice(input logic [15:0] nb, input bit bubble);
    int g;
    if (bubble) begin
      bus.i_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_neurons = nb;
    bus.i_valid   = 1'b1;
    g = 0;
    while (!bus.o_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.o_ready) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL slice_timeout: o_ready=0, required 1");
    end
    @(posedge clk); #1;
    t_last      = cyc;
    bus.i_valid = 1'b0;
  endtask

  task automatic slices(input logic [15:0] nb, input int n, input bit bubble);
    for (int i = 0; i < n; i++) slice(nb, bubble);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [255:0] syn;
  int g0;

  initial begin
    total = 0; bad = 0; cyc = 0; t_last = -100; rdy_cnt = 0; prev_v = 1'b0;
    reset = 1'b1;
    bus.i_start = 1'b0; bus.i_precision = '0; bus.i_signed = 1'b0; bus.i_nbout = '0;
    bus.i_valid = 1'b0; bus.i_neurons = '0; bus.i_synapses = '0; bus.i_result_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  {31'd0, bus.o_valid},  32'd0);
    check("rst_ready",  {31'd0, bus.o_ready},  32'd0);
    check("rst_busy",   {31'd0, bus.o_busy},   32'd0);
    check("rst_result", {16'd0, bus.o_result}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Unsigned P=4, all synapses 1, all-ones slices: 16 x 15.
    rdy_cnt = 0;
    start_op(5'd4, 1'b0, 16'd0, all_syn(16'd1), 1'b1, 16'sd240);
    slices(16'hFFFF, 4, 1'b0);
    wait_drain();
    check("ready_cycles_nostall", rdy_cnt, 32'd4);

    // Signed P=8, lane 0 = 3 with neuron -1, nbout 10.
    syn = '0; syn[15:0] = 16'd3;
    start_op(5'd8, 1'b1, 16'd10, syn, 1'b1, 16'sd7);
    slices(16'h0001, 8, 1'b0);
    wait_drain();

    // Same as the first run with a bubble before every slice.
    rdy_cnt = 0;
    start_op(5'd4, 1'b0, 16'd0, all_syn(16'd1), 1'b1, 16'sd240);
    slices(16'hFFFF, 4, 1'b1);
    wait_drain();
    check("ready_cycles_stall", rdy_cnt, 32'd8);

    // Sum +40000 and -40000 (P=1), and 65535 via P=0 -> PMAX.
`ifdef SERIAL_IP_PREC_SATURATE_EN
    start_op(5'd1, 1'b0, 16'd0, all_syn(16'd2500), 1'b1, 16'sd32767);
    slices(16'hFFFF, 1, 1'b0);
    wait_drain();
    start_op(5'd1, 1'b1, 16'd0, all_syn(16'd2500), 1'b1, -16'sd32768);
    slices(16'hFFFF, 1, 1'b0);
    wait_drain();
    syn = '0; syn[15:0] = 16'd1;
    start_op(5'd0, 1'b0, 16'd0, syn, 1'b1, 16'sd32767);
`else
    start_op(5'd1, 1'b0, 16'd0, all_syn(16'd2500), 1'b1, -16'sd25536);
    slices(16'hFFFF, 1, 1'b0);
    wait_drain();
    start_op(5'd1, 1'b1, 16'd0, all_syn(16'd2500), 1'b1, 16'sd25536);
    slices(16'hFFFF, 1, 1'b0);
    wait_drain();
    syn = '0; syn[15:0] = 16'd1;
    start_op(5'd0, 1'b0, 16'd0, syn, 1'b1, -16'sd1);
`endif
    slices(16'h0001, 16, 1'b0);
    wait_drain();

    // Abort with reset during the third slice; nothing may be reported.
    start_op(5'd4, 1'b0, 16'd0, all_syn(16'd1), 1'b0, 16'sd0);
    slices(16'hFFFF, 2, 1'b0);
    bus.i_neurons = 16'hFFFF; bus.i_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; reset = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("abort_busy",  {31'd0, bus.o_busy},  32'd0);
    check("abort_ready", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    syn = '0; syn[15:0] = 16'd5; syn[31:16] = 16'hFFFE;
    start_op(5'd2, 1'b0, 16'd100, syn, 1'b1, 16'sd111);
    slice(16'h0003, 1'b0);
    slice(16'h0001, 1'b0);
    wait_drain();

    // Held result, then back-to-back start together with result_ready.
    bus.i_result_ready = 1'b0;
    syn = '0; syn[47:32] = 16'hFFFB;
    start_op(5'd3, 1'b0, 16'hFFFB, syn, 1'b1, -16'sd30);
    slice(16'h0004, 1'b0);
    slice(16'h0000, 1'b0);
    slice(16'h0004, 1'b0);
    g0 = 0;
    while (!bus.o_valid && g0 < 20) begin
      @(posedge clk); #1;
      g0++;
    end
    check("held_valid", {31'd0, bus.o_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    bus.i_result_ready = 1'b1;
    syn = '0; syn[15:0] = 16'd1; syn[31:16] = 16'd2; syn[47:32] = 16'd3; syn[63:48] = 16'd4;
    start_op(5'd1, 1'b1, 16'd0, syn, 1'b1, -16'sd7);
    @(negedge clk);
    check("b2b_busy",  {31'd0, bus.o_busy},  32'd1);
    check("b2b_ready", {31'd0, bus.o_ready}, 32'd1);
    check("b2b_valid", {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk); #1;
    slice(16'h000B, 1'b0);
    wait_drain();

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
